// File: rtl/max_sort_extractor_if.sv
// rtl/max_sort_extractor_if.sv - batch load and sorted element stream handshake bundle
interface max_sort_extractor_if #(
  parameter int N = 8,
  parameter int W = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic              i_valid;
  logic              o_ready;
  logic [N*W-1:0]    i_data;
  logic              o_valid;
  logic              i_ready;
  logic [IW-1:0]     o_idx;
  logic [W-1:0]      o_data;
  logic              o_last;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_idx, o_data, o_last
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_idx, o_data, o_last
  );
endinterface

// File: rtl/max_sort_extractor.sv
// rtl/max_sort_extractor.sv - bit-serial max search that streams a batch out in descending order
module max_sort_extractor #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  max_sort_extractor_if.slave  bus
);
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int BW  = $clog2(W) + 1;
  localparam int BIW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, EMIT} state_t;

  state_t            state_q, state_d;
  logic [N*W-1:0]    data_q, data_d;
  logic [N-1:0]      rem_q, rem_d;
  logic [N-1:0]      chi_q, chi_d;
  logic [BW-1:0]     bit_q, bit_d;

  logic [W-1:0]      vals [N];
  logic [N-1:0]      col;
  logic [N-1:0]      ones;
  logic [N-1:0]      sel_oh;
  logic [N-1:0]      rem_next;
  logic [IW-1:0]     sel_idx;
  logic [BIW-1:0]    bit_idx;

  assign bit_idx = bit_q[BIW-1:0];

  // Descending scan so the lowest set candidate wins: ties leave in index order.
  always_comb begin
    vals    = '{default: '0};
    col     = '0;
    sel_idx = '0;
    sel_oh  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      vals[k] = data_q[k*W +: W];
      col[k]  = vals[k][bit_idx];
      if (chi_q[k]) begin
        sel_idx    = IW'(k);
        sel_oh     = '0;
        sel_oh[k]  = 1'b1;
      end
    end
  end

  assign ones     = chi_q & col;
  assign rem_next = rem_q & ~sel_oh;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    chi_d   = chi_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          data_d  = bus.i_data;
          rem_d   = '1;
          chi_d   = '1;
          bit_d   = BW'(W - 1);
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        // A column with no surviving ones leaves the candidate set untouched.
        if (ones != '0) chi_d = ones;
        if (bit_q == '0) state_d = EMIT;
        else             bit_d   = bit_q - 1'b1;
      end
      EMIT: begin
        if (bus.i_ready) begin
          rem_d = rem_next;
          if (rem_next == '0) begin
            state_d = IDLE;
          end else begin
            chi_d   = rem_next;
            bit_d   = BW'(W - 1);
            state_d = SEARCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_ready = (state_q == IDLE);
    bus.o_valid = (state_q == EMIT);
    bus.o_idx   = (state_q == EMIT) ? sel_idx : '0;
    bus.o_data  = (state_q == EMIT) ? vals[sel_idx] : '0;
    // Only one element remains exactly when the remaining mask is the selected bit.
    bus.o_last  = (state_q == EMIT) && (rem_q == sel_oh);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      chi_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      chi_q   <= chi_d;
      bit_q   <= bit_d;
    end
  end
endmodule

// File: tb/tb_max_sort_extractor.sv
// tb/tb_max_sort_extractor.sv - directed vector table plus randomized batches against a stable-sort model
module tb_max_sort_extractor;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic [N*W-1:0]  data;
    logic [N*IW-1:0] eidx;
    logic [N*W-1:0]  evals;
    logic [3:0]      stall;
    logic            poke;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  max_sort_extractor_if #(.N(N), .W(W)) bus ();

  max_sort_extractor #(.N(N), .W(W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Stable descending sort: pick the largest remaining value, lowest index on ties.
  function automatic void ref_sort(input logic [N*W-1:0] d,
                                   output logic [N*IW-1:0] eidx,
                                   output logic [N*W-1:0] evals);
    int v[N];
    bit used[N];
    int best;
    eidx  = '0;
    evals = '0;
    for (int k = 0; k < N; k++) begin
      v[k]    = int'(d[k*W +: W]);
      used[k] = 1'b0;
    end
    for (int p = 0; p < N; p++) begin
      best = -1;
      for (int k = 0; k < N; k++)
        if (!used[k] && (best < 0 || v[k] > v[best])) best = k;
      used[best] = 1'b1;
      eidx[p*IW +: IW] = IW'(best);
      evals[p*W +: W]  = W'(v[best]);
    end
  endfunction

  task automatic load(input logic [N*W-1:0] d, input bit poke);
    int cnt = 0;
    while (!bus.o_ready && cnt < 200) begin
      step();
      cnt++;
    end
    check("load_ready", int'(bus.o_ready), 1);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    step();
    check("busy_after_load", int'(bus.o_ready), 0);
    bus.i_valid = poke;
    bus.i_data  = ~d;
  endtask

  task automatic run_batch(input logic [N*W-1:0] d, input logic [N*IW-1:0] eidx,
                           input logic [N*W-1:0] evals, input int stall, input bit poke);
    int cycles;
    load(d, poke);
    for (int e = 0; e < N; e++) begin
      cycles = 0;
      while (!bus.o_valid && cycles < 4 * W) begin
        step();
        cycles++;
      end
      check("latency", cycles, W);
      check("ready_low", int'(bus.o_ready), 0);
      bus.i_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        step();
        check("stall_valid", int'(bus.o_valid), 1);
        check("stall_idx", int'(bus.o_idx), int'(eidx[e*IW +: IW]));
        check("stall_data", int'(bus.o_data), int'(evals[e*W +: W]));
      end
      check("idx", int'(bus.o_idx), int'(eidx[e*IW +: IW]));
      check("data", int'(bus.o_data), int'(evals[e*W +: W]));
      check("last", int'(bus.o_last), (e == N - 1) ? 1 : 0);
      if (e == N - 1) bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      step();
      bus.i_ready = 1'b0;
    end
    check("done_valid", int'(bus.o_valid), 0);
    check("done_ready", int'(bus.o_ready), 1);
  endtask

  vec_t vecs[5];
  logic [N*W-1:0]  rd;
  logic [N*IW-1:0] ridx;
  logic [N*W-1:0]  rvals;

  initial begin
    vecs[0] = '{data: {4'd1, 4'd9, 4'd9, 4'd3}, eidx: {2'd3, 2'd0, 2'd2, 2'd1},
                evals: {4'd1, 4'd3, 4'd9, 4'd9}, stall: 4'd0, poke: 1'b0};
    vecs[1] = '{data: {4'd1, 4'd9, 4'd9, 4'd3}, eidx: {2'd3, 2'd0, 2'd2, 2'd1},
                evals: {4'd1, 4'd3, 4'd9, 4'd9}, stall: 4'd5, poke: 1'b0};
    vecs[2] = '{data: 16'h0000, eidx: {2'd3, 2'd2, 2'd1, 2'd0},
                evals: 16'h0000, stall: 4'd0, poke: 1'b0};
    vecs[3] = '{data: {4'd1, 4'd9, 4'd9, 4'd3}, eidx: {2'd3, 2'd0, 2'd2, 2'd1},
                evals: {4'd1, 4'd3, 4'd9, 4'd9}, stall: 4'd2, poke: 1'b1};
    vecs[4] = '{data: {4'd5, 4'd5, 4'd5, 4'd15}, eidx: {2'd3, 2'd2, 2'd1, 2'd0},
                evals: {4'd5, 4'd5, 4'd5, 4'd15}, stall: 4'd1, poke: 1'b0};

    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    step();
    step();
    check("rst_ready", int'(bus.o_ready), 1);
    check("rst_valid", int'(bus.o_valid), 0);
    check("rst_idx", int'(bus.o_idx), 0);
    check("rst_data", int'(bus.o_data), 0);
    check("rst_last", int'(bus.o_last), 0);
    i_rst_n = 1'b1;
    step();
    check("post_rst_valid", int'(bus.o_valid), 0);

    for (int i = 0; i < 5; i++)
      run_batch(vecs[i].data, vecs[i].eidx, vecs[i].evals, int'(vecs[i].stall), vecs[i].poke);

    // Reset while the second element is still being searched.
    load({4'd1, 4'd9, 4'd9, 4'd3}, 1'b0);
    for (int c = 0; c < W; c++) step();
    check("pre_rst_valid", int'(bus.o_valid), 1);
    check("pre_rst_idx", int'(bus.o_idx), 1);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    step();
    i_rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(bus.o_valid), 0);
    check("midrst_ready", int'(bus.o_ready), 1);
    step();
    i_rst_n = 1'b1;
    for (int c = 0; c < W + 2; c++) begin
      step();
      check("after_rst_quiet", int'(bus.o_valid), 0);
    end
    run_batch({4'd8, 4'd7, 4'd0, 4'd15}, {2'd1, 2'd2, 2'd3, 2'd0},
              {4'd0, 4'd7, 4'd8, 4'd15}, 0, 1'b0);

    for (int t = 0; t < 1000; t++) begin
      for (int k = 0; k < N; k++)
        rd[k*W +: W] = (t % 2 == 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, (1 << W) - 1));
      ref_sort(rd, ridx, rvals);
      run_batch(rd, ridx, rvals, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
